// File: rtl/vga_scanout_pkg.sv
// Shared timing constants and pixel types for the 640x480 VGA scanout path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_scanout_pkg;

    // Horizontal timing in pixel clocks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
    localparam int HS_START = H_ACTIVE + H_FP;                    // 656
    localparam int HS_END   = HS_START + H_SYNC;                  // 752

    // Vertical timing in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525
    localparam int VS_START = V_ACTIVE + V_FP;                    // 490
    localparam int VS_END   = VS_START + V_SYNC;                  // 492

    // Lines actually backed by SRAM; lines below this show the border colour.
    localparam int FB_ROWS  = 400;

    localparam int CNT_W    = 10;
    localparam int ADDR_W   = 18;

    typedef logic [11:0] rgb_t;

    localparam rgb_t BORDER_RGB = 12'h000;

    // Colour bar k: each RGB channel fully on or off from one bit of k.
    function automatic rgb_t bar_rgb(input logic [2:0] k);
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA beam counters with raw fetch/visible/sync decode.
// Latency: decode is combinational from the counter flops (position of this cycle).
// Backpressure: none; counters advance every pixel clock.
// With SCANOUT_TEST_PATTERN_EN defined, also exports the colour-bar index.
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP,
    parameter int P_FB_ROWS  = FB_ROWS
) (
    input  logic       I_CLK,
    input  logic       I_RST_N,
    output logic       o_fetch,
    output logic       o_visible,
    output logic       o_hs_n,
    output logic       o_vs_n,
    output logic       o_frame_end
`ifdef SCANOUT_TEST_PATTERN_EN
    ,
    output logic [2:0] o_bar
`endif
);

    localparam int HT = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int VT = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(P_H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(P_V_ACTIVE);
    localparam logic [CNT_W-1:0] FB_LINES = CNT_W'(P_FB_ROWS);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(P_H_ACTIVE + P_H_FP);
    localparam logic [CNT_W-1:0] HS_FIN   = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(P_V_ACTIVE + P_V_FP);
    localparam logic [CNT_W-1:0] VS_FIN   = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    // Next beam position: hcnt wraps at end of line, vcnt steps only on that wrap.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Beam counter registers.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Region and sync decode for the current position.
    always_comb begin
        o_fetch     = (hcnt_q < H_ACT) && (vcnt_q < FB_LINES);
        o_visible   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        o_hs_n      = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_FIN));
        o_vs_n      = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_FIN));
        o_frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(P_H_ACTIVE / 8);

    // Bar index is only meaningful inside the active width.
    always_comb begin
        o_bar = 3'(hcnt_q / BAR_W);
    end
`endif

endmodule

// File: rtl/vga_scanout.sv
// VGA framebuffer reader: SRAM address/strobe generation and 3-stage pixel/sync alignment.
// Latency: beam position -> READ/ADDR/VIDEO_ON +1 cycle, SRAM data +2, RGB/HS/VS +3.
// Backpressure: none; free-running at the pixel clock, SRAM must answer every cycle.
// Optional SCANOUT_TEST_PATTERN_EN adds I_TEST_MODE to replace fetched pixels with colour bars.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int   P_H_ACTIVE   = H_ACTIVE,
    parameter int   P_H_FP       = H_FP,
    parameter int   P_H_SYNC     = H_SYNC,
    parameter int   P_H_BP       = H_BP,
    parameter int   P_V_ACTIVE   = V_ACTIVE,
    parameter int   P_V_FP       = V_FP,
    parameter int   P_V_SYNC     = V_SYNC,
    parameter int   P_V_BP       = V_BP,
    parameter int   P_FB_ROWS    = FB_ROWS,
    parameter rgb_t P_BORDER_RGB = BORDER_RGB
) (
    input  logic        I_CLK,
    input  logic        I_RST_N,
`ifdef SCANOUT_TEST_PATTERN_EN
    input  logic        I_TEST_MODE,
`endif
    input  logic [15:0] I_SRAM_DATA,
    output logic [17:0] O_SRAM_ADDR,
    output logic        O_SRAM_READ,
    output logic        O_VIDEO_ON,
    output logic [3:0]  O_VGA_R,
    output logic [3:0]  O_VGA_G,
    output logic [3:0]  O_VGA_B,
    output logic        O_VGA_HS,
    output logic        O_VGA_VS
);

    // Stage-0 decode straight from the beam counters.
    logic fetch0, vis0, hs0, vs0, frame_end0;

    // Stage 1: SRAM request (READ doubles as the fetch flag for the next stage).
    logic              sram_read_q, sram_read_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [ADDR_W-1:0] addr_cnt_q,  addr_cnt_d;
    logic              vis1_q, hs1_q, vs1_q;

    // Stage 2: SRAM data is on I_SRAM_DATA during this stage.
    logic              fetch2_q, vis2_q, hs2_q, vs2_q;

    // Stage 3: DAC outputs.
    rgb_t              rgb_q, rgb_d;
    logic              hs_q, vs_q;

    // Upper nibble of the pixel word carries no colour.
    logic [3:0]        sram_hi_unused;
    assign sram_hi_unused = I_SRAM_DATA[15:12];

`ifdef SCANOUT_TEST_PATTERN_EN
    logic [2:0] bar0, bar1_q, bar2_q;
`endif

    vga_timing_gen #(
        .P_H_ACTIVE (P_H_ACTIVE),
        .P_H_FP     (P_H_FP),
        .P_H_SYNC   (P_H_SYNC),
        .P_H_BP     (P_H_BP),
        .P_V_ACTIVE (P_V_ACTIVE),
        .P_V_FP     (P_V_FP),
        .P_V_SYNC   (P_V_SYNC),
        .P_V_BP     (P_V_BP),
        .P_FB_ROWS  (P_FB_ROWS)
    ) u_timing (
        .I_CLK       (I_CLK),
        .I_RST_N     (I_RST_N),
        .o_fetch     (fetch0),
        .o_visible   (vis0),
        .o_hs_n      (hs0),
        .o_vs_n      (vs0),
        .o_frame_end (frame_end0)
`ifdef SCANOUT_TEST_PATTERN_EN
        ,
        .o_bar       (bar0)
`endif
    );

    // Running address: issue current count on each fetch, restart at end of frame.
    always_comb begin
        sram_read_d = fetch0;
        sram_addr_d = sram_addr_q;
        addr_cnt_d  = addr_cnt_q;
        if (fetch0) begin
            sram_addr_d = addr_cnt_q;
            addr_cnt_d  = addr_cnt_q + 1'b1;
        end
        if (frame_end0) begin
            addr_cnt_d = '0;
        end
    end

    // Colour select for the pixel whose SRAM word is arriving now.
    always_comb begin
        rgb_d = '0;
        if (fetch2_q) begin
            rgb_d = I_SRAM_DATA[11:0];
`ifdef SCANOUT_TEST_PATTERN_EN
            if (I_TEST_MODE) begin
                rgb_d = bar_rgb(bar2_q);
            end
`endif
        end else if (vis2_q) begin
            rgb_d = P_BORDER_RGB;
        end
    end

    // Request, alignment pipeline and output registers; syncs idle high in reset.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            sram_read_q <= 1'b0;
            sram_addr_q <= '0;
            addr_cnt_q  <= '0;
            vis1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            fetch2_q    <= 1'b0;
            vis2_q      <= 1'b0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
`ifdef SCANOUT_TEST_PATTERN_EN
            bar1_q      <= '0;
            bar2_q      <= '0;
`endif
        end else begin
            sram_read_q <= sram_read_d;
            sram_addr_q <= sram_addr_d;
            addr_cnt_q  <= addr_cnt_d;
            vis1_q      <= vis0;
            hs1_q       <= hs0;
            vs1_q       <= vs0;
            fetch2_q    <= sram_read_q;
            vis2_q      <= vis1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            rgb_q       <= rgb_d;
            hs_q        <= hs2_q;
            vs_q        <= vs2_q;
`ifdef SCANOUT_TEST_PATTERN_EN
            bar1_q      <= bar0;
            bar2_q      <= bar1_q;
`endif
        end
    end

    assign O_SRAM_ADDR = sram_addr_q;
    assign O_SRAM_READ = sram_read_q;
    assign O_VIDEO_ON  = sram_read_q;
    assign O_VGA_R     = rgb_q[11:8];
    assign O_VGA_G     = rgb_q[7:4];
    assign O_VGA_B     = rgb_q[3:0];
    assign O_VGA_HS    = hs_q;
    assign O_VGA_VS    = vs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a scaled-down display geometry so whole frames fit in a short run.
// Reference model maps every clock edge index to a beam position with plain arithmetic.
module tb_vga_scanout;

    localparam int HA = 40, HFP = 4, HSY = 8, HBP = 6;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int HSS = HA + HFP, HSE = HSS + HSY;
    localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int VSS = VA + VFP;
    localparam int FB = 25;
    localparam int FRAME = HT * VT;
    localparam int BAR_W = HA / 8;
    localparam logic [11:0] BORDER = 12'h123;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tm = 1'b0;
    logic [15:0] sram_data;
    logic [17:0] addr;
    logic        rd, von, hs, vs;
    logic [3:0]  r, g, b;
    logic [11:0] rgb_o;

    int          tests = 0;
    int          errs = 0;
    int          n = 0;
    logic [17:0] m_addr = '0;
    logic [11:0] key;

    always #5 clk = ~clk;

    assign rgb_o = {r, g, b};

    vga_scanout #(
        .P_H_ACTIVE(HA), .P_H_FP(HFP), .P_H_SYNC(HSY), .P_H_BP(HBP),
        .P_V_ACTIVE(VA), .P_V_FP(VFP), .P_V_SYNC(VSY), .P_V_BP(VBP),
        .P_FB_ROWS(FB), .P_BORDER_RGB(BORDER)
    ) dut (
        .I_CLK       (clk),
        .I_RST_N     (rst_n),
`ifdef SCANOUT_TEST_PATTERN_EN
        .I_TEST_MODE (tm),
`endif
        .I_SRAM_DATA (sram_data),
        .O_SRAM_ADDR (addr),
        .O_SRAM_READ (rd),
        .O_VIDEO_ON  (von),
        .O_VGA_R     (r),
        .O_VGA_G     (g),
        .O_VGA_B     (b),
        .O_VGA_HS    (hs),
        .O_VGA_VS    (vs)
    );

    // SRAM: one-cycle read latency, low 12 bits scrambled by key, junk in the top nibble.
    always @(posedge clk) sram_data <= {4'($urandom), addr[11:0] ^ key};

    // ---------------- reference model (k = beam-position index since reset) -------------
    function automatic int ph(int k); return k % HT; endfunction
    function automatic int pv(int k); return (k / HT) % VT; endfunction
    function automatic logic m_fetch(int k); return (ph(k) < HA) && (pv(k) < FB); endfunction
    function automatic logic m_vis(int k); return (ph(k) < HA) && (pv(k) < VA); endfunction

    function automatic logic [11:0] m_rgb(int nn);
        int k, bk;
        if (nn < 3) return 12'h000;
        k = nn - 3;
        if (m_fetch(k)) begin
            if (tm) begin
                bk = ph(k) / BAR_W;
                return {((bk & 4) != 0) ? 4'hF : 4'h0,
                        ((bk & 2) != 0) ? 4'hF : 4'h0,
                        ((bk & 1) != 0) ? 4'hF : 4'h0};
            end
            return 12'(pv(k) * HA + ph(k)) ^ key;
        end
        if (m_vis(k)) return BORDER;
        return 12'h000;
    endfunction

    function automatic logic m_hs(int nn);
        if (nn < 3) return 1'b1;
        return !((ph(nn - 3) >= HSS) && (ph(nn - 3) < HSE));
    endfunction

    function automatic logic m_vs(int nn);
        if (nn < 3) return 1'b1;
        return !((pv(nn - 3) >= VSS) && (pv(nn - 3) < VSS + VSY));
    endfunction

    // One clock edge; leaves the bench at the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        n++;
        if (m_fetch(n - 1)) m_addr = 18'(pv(n - 1) * HA + ph(n - 1));
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        key = 12'($urandom);
        repeat (3) @(negedge clk);
        tests++; if (rd !== 1'b0) begin errs++; $display("FAIL rst_read got %b want 0", rd); end
        tests++; if (von !== 1'b0) begin errs++; $display("FAIL rst_video_on got %b want 0", von); end
        tests++; if (addr !== 18'd0) begin errs++; $display("FAIL rst_addr got %0d want 0", addr); end
        tests++; if (rgb_o !== 12'h000) begin errs++; $display("FAIL rst_rgb got %h want 000", rgb_o); end
        tests++; if (hs !== 1'b1) begin errs++; $display("FAIL rst_hs got %b want 1", hs); end
        tests++; if (vs !== 1'b1) begin errs++; $display("FAIL rst_vs got %b want 1", vs); end
        rst_n = 1'b1;
        n = 0;
        m_addr = '0;
    endtask

    task automatic test_frame(input int cycles, input string tag);
        int reads;
        logic [11:0] exp_rgb;
        reads = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            exp_rgb = m_rgb(n);
            tests++; if (rd !== m_fetch(n - 1)) begin errs++;
                $display("FAIL %s read n=%0d got %b want %b", tag, n, rd, m_fetch(n - 1)); end
            tests++; if (von !== m_fetch(n - 1)) begin errs++;
                $display("FAIL %s video_on n=%0d got %b want %b", tag, n, von, m_fetch(n - 1)); end
            tests++; if (addr !== m_addr) begin errs++;
                $display("FAIL %s addr n=%0d got %0d want %0d", tag, n, addr, m_addr); end
            tests++; if (rgb_o !== exp_rgb) begin errs++;
                $display("FAIL %s rgb n=%0d got %h want %h", tag, n, rgb_o, exp_rgb); end
            tests++; if (hs !== m_hs(n)) begin errs++;
                $display("FAIL %s hs n=%0d got %b want %b", tag, n, hs, m_hs(n)); end
            tests++; if (vs !== m_vs(n)) begin errs++;
                $display("FAIL %s vs n=%0d got %b want %b", tag, n, vs, m_vs(n)); end
            if (n >= 3 && ((n - 3) % FRAME) == 5 && !tm) begin
                tests++; if (rgb_o !== (12'h005 ^ key)) begin errs++;
                    $display("FAIL %s pixel5 got %h want %h", tag, rgb_o, 12'h005 ^ key); end
            end
            if (n >= 3 && ((n - 3) % FRAME) == BAR_W + 1 && tm) begin
                tests++; if (rgb_o !== 12'h00F) begin errs++;
                    $display("FAIL %s bar1 got %h want 00f", tag, rgb_o); end
            end
            if (n >= 3 && ((n - 3) % FRAME) == HA - 1 && tm) begin
                tests++; if (rgb_o !== 12'hFFF) begin errs++;
                    $display("FAIL %s bar7 got %h want fff", tag, rgb_o); end
            end
            if (i < FRAME && rd === 1'b1) reads++;
        end
        if (cycles >= FRAME) begin
            tests++; if (reads != FB * HA) begin errs++;
                $display("FAIL %s read_count got %0d want %0d", tag, reads, FB * HA); end
        end
    endtask

    task automatic test_line_timing();
        logic prev_hs, prev_vs;
        int hs_fall, vs_fall;
        prev_hs = hs; prev_vs = vs;
        hs_fall = -1; vs_fall = -1;
        for (int i = 0; i < 2 * FRAME + HT; i++) begin
            tick();
            if (prev_hs === 1'b1 && hs === 1'b0) begin
                tests++; if (((n - 3) % HT) != HSS) begin errs++;
                    $display("FAIL hs_phase n=%0d got %0d want %0d", n, (n - 3) % HT, HSS); end
                if (hs_fall >= 0) begin
                    tests++; if (n - hs_fall != HT) begin errs++;
                        $display("FAIL hs_period got %0d want %0d", n - hs_fall, HT); end
                end
                hs_fall = n;
            end
            if (prev_hs === 1'b0 && hs === 1'b1 && hs_fall >= 0) begin
                tests++; if (n - hs_fall != HSY) begin errs++;
                    $display("FAIL hs_width got %0d want %0d", n - hs_fall, HSY); end
            end
            if (prev_vs === 1'b1 && vs === 1'b0) begin
                tests++; if (((n - 3) % FRAME) != VSS * HT) begin errs++;
                    $display("FAIL vs_phase got %0d want %0d", (n - 3) % FRAME, VSS * HT); end
                if (vs_fall >= 0) begin
                    tests++; if (n - vs_fall != FRAME) begin errs++;
                        $display("FAIL vs_period got %0d want %0d", n - vs_fall, FRAME); end
                end
                vs_fall = n;
            end
            if (prev_vs === 1'b0 && vs === 1'b1 && vs_fall >= 0) begin
                tests++; if (n - vs_fall != VSY * HT) begin errs++;
                    $display("FAIL vs_width got %0d want %0d", n - vs_fall, VSY * HT); end
            end
            prev_hs = hs; prev_vs = vs;
        end
        tests++; if (vs_fall < 0) begin errs++; $display("FAIL vs_seen got none want fall"); end
    endtask

    task automatic test_video_on();
        logic prev, partial;
        int run, falls;
        prev = von; partial = von; run = 0; falls = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            tests++; if (von !== rd) begin errs++;
                $display("FAIL von_eq_read n=%0d got %b want %b", n, von, rd); end
            if (von === 1'b1) run++;
            else if (prev === 1'b1) begin
                if (!partial) begin
                    tests++; if (run != HA) begin errs++;
                        $display("FAIL von_run got %0d want %0d", run, HA); end
                    tests++; if (pv(n - 2) >= FB) begin errs++;
                        $display("FAIL von_line got %0d want <%0d", pv(n - 2), FB); end
                end
                falls++; partial = 1'b0; run = 0;
            end
            prev = von;
        end
        tests++; if (falls != FB) begin errs++;
            $display("FAIL von_lines got %0d want %0d", falls, FB); end
    endtask

    task automatic test_reset_midframe();
        int hr, vr;
        logic found;
        hr = $urandom_range(HA - 1);
        vr = $urandom_range(FB - 1);
        found = 1'b0;
        for (int i = 0; i < FRAME + HT && !found; i++) begin
            tick();
            if (ph(n) == hr && pv(n) == vr) found = 1'b1;
        end
        tests++; if (!found) begin errs++; $display("FAIL midrst_reach got none want (%0d,%0d)", hr, vr); end
        rst_n = 1'b0;
        #1;
        tests++; if (rd !== 1'b0) begin errs++; $display("FAIL midrst_read got %b want 0", rd); end
        tests++; if (von !== 1'b0) begin errs++; $display("FAIL midrst_von got %b want 0", von); end
        tests++; if (addr !== 18'd0) begin errs++; $display("FAIL midrst_addr got %0d want 0", addr); end
        tests++; if (rgb_o !== 12'h000) begin errs++; $display("FAIL midrst_rgb got %h want 000", rgb_o); end
        tests++; if (hs !== 1'b1 || vs !== 1'b1) begin errs++;
            $display("FAIL midrst_sync got %b%b want 11", hs, vs); end
        repeat (3) begin
            @(negedge clk);
            tests++; if (rd !== 1'b0 || addr !== 18'd0) begin errs++;
                $display("FAIL midrst_hold got rd=%b addr=%0d want 0/0", rd, addr); end
        end
        key = 12'($urandom);
        rst_n = 1'b1;
        n = 0;
        m_addr = '0;
        test_frame(FRAME + 3, "post_rst");
    endtask

`ifdef SCANOUT_TEST_PATTERN_EN
    task automatic test_pattern();
        tm = 1'b1;
        test_frame(FRAME, "pattern");
        tm = 1'b0;
        test_frame(HT * 2, "pattern_off");
    endtask
`endif

    initial begin
        test_reset();
        test_frame(FRAME + 3, "frame0");
        test_line_timing();
        test_video_on();
        test_reset_midframe();
`ifdef SCANOUT_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
